// File: rtl/byte_basher_pkg.sv
// Shared types and constants for the byte-basher GPIO/hit path.
package byte_basher_pkg;

    localparam int unsigned BOX_W = 3;
    localparam logic [BOX_W-1:0] BOX_NONE = 3'd0;

    typedef enum logic [1:0] {
        IDLE,
        QUALIFY,
        HELD,
        LOCKOUT
    } hit_state_e;

endpackage

// File: rtl/gpio_sync.sv
// Two-flop synchronizer for asynchronous GPIO inputs, any width.
module gpio_sync #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/pad_hit_detector.sv
// Synchronizes and debounces the Arduino pad address and emits one hit pulse per strike.
// Optional target compare (hit_match/hit_miss) is built when TARGET_MATCH_EN is defined.
module pad_hit_detector
    import byte_basher_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned LOCKOUT_CYCLES  = 2500000,
    parameter int unsigned CNT_W           = 10
) (
    input  logic             CLOCK_50,
    input  logic             resetn,
    input  logic [BOX_W-1:0] gpio_in,
    input  logic             arm,
    input  logic             count_clr,
    output logic             hit_valid,
    output logic [BOX_W-1:0] box_addr,
    output logic             pad_held,
    output logic             busy,
`ifdef TARGET_MATCH_EN
    input  logic [BOX_W-1:0] target_box,
    output logic             hit_match,
    output logic             hit_miss,
`endif
    output logic [CNT_W-1:0] hit_count
);

    localparam int unsigned CntMax =
        (DEBOUNCE_CYCLES > LOCKOUT_CYCLES) ? DEBOUNCE_CYCLES : LOCKOUT_CYCLES;
    localparam int unsigned CntW = $clog2(CntMax + 1);
    localparam logic [CntW-1:0] CntOne   = CntW'(1);
    localparam logic [CntW-1:0] DebLast  = CntW'(DEBOUNCE_CYCLES);
    localparam logic [CntW-1:0] LockLast = CntW'(LOCKOUT_CYCLES - 1);

    logic [BOX_W-1:0] sync_q;
    hit_state_e       state_q, state_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [BOX_W-1:0] cand_q, cand_d;
    logic [BOX_W-1:0] box_q, box_d;
    logic             hit_q, hit_d;
    logic [CNT_W-1:0] count_q;

    gpio_sync #(
        .WIDTH (BOX_W)
    ) u_gpio_sync (
        .clk   (CLOCK_50),
        .rst_n (resetn),
        .d     (gpio_in),
        .q     (sync_q)
    );

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            cand_q  <= BOX_NONE;
            box_q   <= BOX_NONE;
            hit_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cand_q  <= cand_d;
            box_q   <= box_d;
            hit_q   <= hit_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cand_d  = cand_q;
        box_d   = box_q;
        hit_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (arm && sync_q != BOX_NONE) begin
                    state_d = QUALIFY;
                    cand_d  = sync_q;
                    cnt_d   = CntOne;
                end
            end
            QUALIFY: begin
                if (!arm || sync_q == BOX_NONE) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == DebLast) begin
                    state_d = HELD;
                    hit_d   = 1'b1;
                    box_d   = cand_q;
                    cnt_d   = '0;
                end else if (sync_q == cand_q) begin
                    cnt_d = cnt_q + CntOne;
                end else begin
                    cand_d = sync_q;
                    cnt_d  = CntOne;
                end
            end
            // Only a sustained all-zero sample run counts as a release; pad changes are ignored.
            HELD: begin
                if (cnt_q == DebLast) begin
                    state_d = LOCKOUT;
                    cnt_d   = '0;
                end else if (sync_q == BOX_NONE) begin
                    cnt_d = cnt_q + CntOne;
                end else begin
                    cnt_d = '0;
                end
            end
            LOCKOUT: begin
                if (cnt_q == LockLast) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CntOne;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Clear takes priority over a coincident hit; saturates at all-ones.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            count_q <= '0;
        end else if (count_clr) begin
            count_q <= '0;
        end else if (hit_q && count_q != {CNT_W{1'b1}}) begin
            count_q <= count_q + CNT_W'(1);
        end
    end

`ifdef TARGET_MATCH_EN
    logic match_q, miss_q;
    logic match_d, miss_d;

    always_comb begin
        match_d = hit_d && (target_box != BOX_NONE) && (cand_q == target_box);
        miss_d  = hit_d && !match_d;
    end

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            match_q <= 1'b0;
            miss_q  <= 1'b0;
        end else begin
            match_q <= match_d;
            miss_q  <= miss_d;
        end
    end

    always_comb begin
        hit_match = match_q;
        hit_miss  = miss_q;
    end
`endif

    always_comb begin
        hit_valid = hit_q;
        box_addr  = box_q;
        hit_count = count_q;
        busy      = (state_q != IDLE);
        pad_held  = (state_q == HELD);
    end

endmodule

// File: tb/tb_pad_hit_detector.sv
// Directed bench for pad_hit_detector with short debounce/lockout (4/8) and a 2-bit counter.
// Exercises hit_match/hit_miss too when TARGET_MATCH_EN is defined.
module tb_pad_hit_detector;

    localparam int unsigned Deb  = 4;
    localparam int unsigned Lock = 8;
    localparam int unsigned Cw   = 2;

    logic          clk       = 1'b0;
    logic          resetn    = 1'b0;
    logic [2:0]    gpio_in   = 3'd0;
    logic          arm       = 1'b0;
    logic          count_clr = 1'b0;
    logic          hit_valid;
    logic [2:0]    box_addr;
    logic          pad_held;
    logic          busy;
    logic [Cw-1:0] hit_count;
`ifdef TARGET_MATCH_EN
    logic [2:0]    target_box = 3'd4;
    logic          hit_match;
    logic          hit_miss;
`endif

    pad_hit_detector #(
        .DEBOUNCE_CYCLES (Deb),
        .LOCKOUT_CYCLES  (Lock),
        .CNT_W           (Cw)
    ) dut (
        .CLOCK_50   (clk),
        .resetn     (resetn),
        .gpio_in    (gpio_in),
        .arm        (arm),
        .count_clr  (count_clr),
        .hit_valid  (hit_valid),
        .box_addr   (box_addr),
        .pad_held   (pad_held),
        .busy       (busy),
`ifdef TARGET_MATCH_EN
        .target_box (target_box),
        .hit_match  (hit_match),
        .hit_miss   (hit_miss),
`endif
        .hit_count  (hit_count)
    );

    always #5 clk = ~clk;

    int   n_tests     = 0;
    int   n_fail      = 0;
    int   cyc         = 0;
    int   base        = 0;
    int   pulses      = 0;
    int   first_pulse = -1;
    int   doubles     = 0;
    logic prev_hv     = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // One clock; samples 1 ns after the rising edge and tallies hit pulses.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (hit_valid === 1'b1) begin
            if (pulses == 0) first_pulse = cyc;
            pulses++;
            if (prev_hv) doubles++;
        end
        prev_hv = hit_valid;
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    task automatic mark();
        pulses      = 0;
        first_pulse = -1;
        base        = cyc;
    endtask

    task automatic strike(input logic [2:0] pad);
        gpio_in = pad;
        run(10);
        gpio_in = 3'd0;
        run(20);
    endtask

    initial begin
        run(2);
        check("rst_hit_valid", hit_valid, 0);
        check("rst_box_addr", box_addr, 0);
        check("rst_pad_held", pad_held, 0);
        check("rst_busy", busy, 0);
        check("rst_hit_count", hit_count, 0);
        resetn = 1'b1;
        arm    = 1'b1;
        run(2);

        // 1: clean press
        mark();
        gpio_in = 3'd3;
        run(30);
        check("t1_pulses", pulses, 1);
        check("t1_latency", first_pulse - base, 7);
        check("t1_box_addr", box_addr, 3);
        check("t1_count", hit_count, 1);
        check("t1_pad_held", pad_held, 1);
        gpio_in = 3'd0;
        run(3);
        check("t1_held_after_release", pad_held, 1);
        run(17);
        check("t1_released", pad_held, 0);
        check("t1_idle", busy, 0);
        check("t1_no_extra", pulses, 1);

        // 2: bounce then steady
        mark();
        repeat (2) begin
            gpio_in = 3'd3;
            run(2);
            gpio_in = 3'd0;
            run(2);
        end
        check("t2_no_early", pulses, 0);
        gpio_in = 3'd3;
        run(20);
        check("t2_pulses", pulses, 1);
        check("t2_latency", first_pulse - base, 15);
        check("t2_count", hit_count, 2);
        gpio_in = 3'd0;
        run(20);

        // 3: candidate switch
        mark();
        gpio_in = 3'd2;
        run(2);
        gpio_in = 3'd5;
        run(15);
        check("t3_pulses", pulses, 1);
        check("t3_latency", first_pulse - base, 9);
        check("t3_box_addr", box_addr, 5);
        check("t3_count", hit_count, 3);
        gpio_in = 3'd0;
        run(20);
        count_clr = 1'b1;
        tick();
        count_clr = 1'b0;
        check("clr_count", hit_count, 0);

        // 4: repress during lockout is ignored
        mark();
        gpio_in = 3'd3;
        run(10);
        check("t4_first", pulses, 1);
        gpio_in = 3'd0;
        run(8);
        check("t4_lockout_busy", busy, 1);
        check("t4_lockout_not_held", pad_held, 0);
        gpio_in = 3'd3;
        run(4);
        gpio_in = 3'd0;
        run(13);
        check("t4_no_lockout_hit", pulses, 1);
        check("t4_idle", busy, 0);
        gpio_in = 3'd3;
        run(10);
        check("t4_second", pulses, 2);
        check("t4_count", hit_count, 2);
        gpio_in = 3'd0;
        run(20);

        // 5: arm gating, disarm while held, saturation, clear priority
        count_clr = 1'b1;
        tick();
        count_clr = 1'b0;
        mark();
        arm     = 1'b0;
        gpio_in = 3'd6;
        run(15);
        check("t5_disarmed_pulses", pulses, 0);
        check("t5_disarmed_count", hit_count, 0);
        check("t5_disarmed_busy", busy, 0);
        gpio_in = 3'd0;
        run(4);
        arm     = 1'b1;
        gpio_in = 3'd6;
        run(10);
        check("t5_armed_pulse", pulses, 1);
        arm = 1'b0;
        run(1);
        check("t5_disarm_held", pad_held, 1);
        gpio_in = 3'd0;
        run(20);
        check("t5_disarm_no_extra", pulses, 1);
        check("t5_disarm_idle", busy, 0);
        check("t5_count1", hit_count, 1);
        arm = 1'b1;
        strike(3'd1);
        strike(3'd2);
        strike(3'd7);
        check("t5_strikes", pulses, 4);
        check("t5_saturate", hit_count, 3);
        mark();
        gpio_in = 3'd1;
        run(7);
        check("t5_clr_pulse", hit_valid, 1);
`ifdef TARGET_MATCH_EN
        check("t5_miss", hit_miss, 1);
        check("t5_no_match", hit_match, 0);
`endif
        count_clr = 1'b1;
        tick();
        count_clr = 1'b0;
        check("t5_clr_wins", hit_count, 0);
        tick();
        check("t5_clr_stays", hit_count, 0);
        gpio_in = 3'd0;
        run(20);

        // 6: async reset while held, requalify after release
        gpio_in = 3'd4;
        run(10);
        check("t6_held", pad_held, 1);
        check("t6_count", hit_count, 1);
        resetn = 1'b0;
        #1;
        check("t6_rst_box", box_addr, 0);
        check("t6_rst_held", pad_held, 0);
        check("t6_rst_busy", busy, 0);
        check("t6_rst_count", hit_count, 0);
        check("t6_rst_hit", hit_valid, 0);
        run(2);
        resetn = 1'b1;
        mark();
        run(6);
        check("t6_no_early", pulses, 0);
        tick();
        check("t6_pulse", hit_valid, 1);
        check("t6_box_addr", box_addr, 4);
`ifdef TARGET_MATCH_EN
        check("t6_match", hit_match, 1);
        check("t6_no_miss", hit_miss, 0);
`endif
        gpio_in = 3'd0;
        run(20);

        check("never_double_pulse", doubles, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
